agu_ntt_param: RTL and testbench

//  Parametrised NTT address-generation unit: emits, per accepted group, 2**RADIX_K data

---
 rtl/agu_ntt_param_if.sv | 14 +
 rtl/agu_ntt_param.sv | 162 ++++++++++++++++
 tb/tb_agu_ntt_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/agu_ntt_param_if.sv
// rtl/agu_ntt_param_if.sv - group output stream bundle of the NTT address-generation unit
interface agu_ntt_param_if #(
    parameter int LANES = 16,
    parameter int D_W   = 8,
    parameter int STG_W = 2
);
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*D_W-1:0]   order_o;
    logic [STG_W-1:0]       stage_o;

    modport master (output out_valid, output order_o, output stage_o, input out_ready);
    modport slave  (input out_valid, input order_o, input stage_o, output out_ready);
endinterface

// File: rtl/agu_ntt_param.sv
// rtl/agu_ntt_param.sv - radix-2**RADIX_K NTT butterfly address generator with valid/ready output
module agu_ntt_param #(
    parameter int LOGN    = 8,
    parameter int RADIX_K = 4,
    parameter int D_W     = LOGN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic inv_mode,
    input  logic abort,
    output logic busy,
    output logic done,
    agu_ntt_param_if.master grp
);
    localparam int NSTG  = LOGN / RADIX_K;
    localparam int LANES = 2**RADIX_K;
    localparam int STG_W = $clog2(NSTG) + 1;
    localparam int SH_W  = $clog2(LOGN + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_inv;
    logic                   r_out_valid;
    logic                   r_done;
    logic [STG_W-1:0]       r_stage;
    logic [STG_W-1:0]       r_out_stage;
    logic [LOGN-1:0]        r_j;
    logic [LOGN-1:0]        r_i;
    logic [LANES*D_W-1:0]   r_order;

    logic                   w_idle_go;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_cur_inv;
    logic [STG_W-1:0]       w_cur_stage;
    logic [LOGN-1:0]        w_cur_j;
    logic [LOGN-1:0]        w_cur_i;
    logic [SH_W-1:0]        w_jbits;
    logic [SH_W-1:0]        w_ibits;
    logic [LOGN-1:0]        w_imax;
    logic [LOGN-1:0]        w_jmax;
    logic [LOGN-1:0]        w_jrev;
    logic                   w_i_wrap;
    logic                   w_j_wrap;
    logic                   w_last_stg;
    logic                   w_last_grp;
    logic [STG_W-1:0]       w_nxt_stage;
    logic [LOGN-1:0]        w_nxt_j;
    logic [LOGN-1:0]        w_nxt_i;
    logic [LANES*D_W-1:0]   w_order;

    // In IDLE the accepted start loads group 0 directly, so counters are taken from their start values.
    always_comb begin
        w_idle_go   = (r_state == S_IDLE) && start && !abort;
        w_accept    = r_out_valid && grp.out_ready;
        w_load      = w_idle_go ||
                      ((r_state == S_RUN) && !abort && (!r_out_valid || grp.out_ready));
        w_cur_inv   = (r_state == S_IDLE) ? inv_mode : r_inv;
        w_cur_stage = (r_state == S_IDLE) ? (inv_mode ? STG_W'(NSTG - 1) : '0) : r_stage;
        w_cur_j     = (r_state == S_IDLE) ? '0 : r_j;
        w_cur_i     = (r_state == S_IDLE) ? '0 : r_i;
    end

    // Full-width reversal of j lands bitrev(j, jbits) already scaled by 2**(LOGN-jbits), since j < 2**jbits.
    always_comb begin
        w_jbits = SH_W'(RADIX_K) * SH_W'(w_cur_stage);
        w_ibits = SH_W'(LOGN - RADIX_K) - w_jbits;
        w_imax  = (LOGN'(1) << w_ibits) - LOGN'(1);
        w_jmax  = (LOGN'(1) << w_jbits) - LOGN'(1);
        w_jrev  = '0;
        for (int b = 0; b < LOGN; b++) begin
            w_jrev[b] = w_cur_j[LOGN-1-b];
        end
        w_order = '0;
        for (int m = 0; m < LANES; m++) begin
            w_order[m*D_W +: D_W] = D_W'(w_jrev + (LOGN'(m) << w_ibits) + w_cur_i);
        end
    end

    always_comb begin
        w_last_stg  = w_cur_inv ? (w_cur_stage == '0) : (w_cur_stage == STG_W'(NSTG - 1));
        w_i_wrap    = (w_cur_i == w_imax);
        w_j_wrap    = (w_cur_j == w_jmax);
        w_last_grp  = w_i_wrap && w_j_wrap && w_last_stg;
        w_nxt_i     = w_i_wrap ? '0 : w_cur_i + LOGN'(1);
        w_nxt_j     = w_cur_j;
        w_nxt_stage = w_cur_stage;
        if (w_i_wrap) begin
            w_nxt_j = w_j_wrap ? '0 : w_cur_j + LOGN'(1);
            if (w_j_wrap && !w_last_stg) begin
                w_nxt_stage = w_cur_inv ? w_cur_stage - STG_W'(1) : w_cur_stage + STG_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_idle_go) begin
                    w_state_nxt = w_last_grp ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_load && w_last_grp) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (abort || w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_stage     <= '0;
            r_out_stage <= '0;
            r_j         <= '0;
            r_i         <= '0;
            r_order     <= '0;
        end else begin
            r_done <= (r_state == S_FLUSH) && !abort && w_accept;
            if (w_load) begin
                r_inv       <= w_cur_inv;
                r_stage     <= w_nxt_stage;
                r_j         <= w_nxt_j;
                r_i         <= w_nxt_i;
                r_order     <= w_order;
                r_out_stage <= w_cur_stage;
                r_out_valid <= 1'b1;
            end else if (abort || ((r_state == S_FLUSH) && w_accept)) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy          = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done          = r_done;
    assign grp.out_valid = r_out_valid;
    assign grp.order_o   = r_order;
    assign grp.stage_o   = r_out_stage;
endmodule

// File: tb/tb_agu_ntt_param.sv
// tb/tb_agu_ntt_param.sv - randomized scoreboard bench for agu_ntt_param
module tb_agu_ntt_param;
    localparam int LOGN    = 8;
    localparam int RADIX_K = 4;
    localparam int D_W     = 8;
    localparam int NSTG    = LOGN / RADIX_K;
    localparam int LANES   = 2**RADIX_K;
    localparam int STG_W   = $clog2(NSTG) + 1;
    localparam int TOTAL   = NSTG * 2**(LOGN - RADIX_K);

    typedef struct {
        logic [LANES*D_W-1:0] ord;
        logic [STG_W-1:0]     stg;
    } grp_t;

    logic clk;
    logic rst_n;
    logic start;
    logic inv_mode;
    logic abort;
    logic busy;
    logic done;

    int   n_vec;
    int   n_err;
    grp_t exp_q[$];

    agu_ntt_param_if #(.LANES(LANES), .D_W(D_W), .STG_W(STG_W)) grp ();

    agu_ntt_param #(.LOGN(LOGN), .RADIX_K(RADIX_K), .D_W(D_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inv_mode (inv_mode),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .grp      (grp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitrev(input int v, input int nb);
        int r;
        r = 0;
        for (int b = 0; b < nb; b++) begin
            if (v[b]) r = r | (1 << (nb - 1 - b));
        end
        return r;
    endfunction

    task automatic build(input bit inv);
        exp_q.delete();
        for (int s = 0; s < NSTG; s++) begin
            int l;
            int jb;
            int ib;
            l  = inv ? (NSTG - 1 - s) : s;
            jb = RADIX_K * l;
            ib = LOGN - RADIX_K * (l + 1);
            for (int j = 0; j < 2**jb; j++) begin
                for (int i = 0; i < 2**ib; i++) begin
                    grp_t g;
                    for (int m = 0; m < LANES; m++) begin
                        g.ord[m*D_W +: D_W] = D_W'(bitrev(j, jb) * 2**(LOGN - jb) + m * 2**ib + i);
                    end
                    g.stg = STG_W'(l);
                    exp_q.push_back(g);
                end
            end
        end
    endtask

    task automatic run_job(input bit inv, input int rdy_pct, input int stall_grp, input int abort_at,
                           input bit spam, input bit pre, input bit chain, input bit chain_inv);
        int idx;
        int cyc;
        int stall;
        int done_cnt;
        idx = 0; cyc = 0; stall = 0; done_cnt = 0;
        build(inv);
        if (!pre) begin
            start = 1'b1; inv_mode = inv;
            @(negedge clk);
            start = 1'b0;
        end
        chk_eq("first_valid", grp.out_valid, 1);
        while (idx < TOTAL && cyc < 3000) begin
            grp.out_ready = ($urandom_range(99) < rdy_pct);
            if (idx == stall_grp && stall < 5) begin
                grp.out_ready = 1'b0;
                stall++;
            end
            if (spam) begin
                start    = ($urandom_range(3) == 0);
                inv_mode = $urandom_range(1);
            end
            if (done) done_cnt++;
            chk_eq("busy_run", busy, 1);
            chk_eq("valid_run", grp.out_valid, 1);
            chk_eq("order", grp.order_o, exp_q[idx].ord);
            chk_eq("stage", grp.stage_o, exp_q[idx].stg);
            if (idx == abort_at) begin
                abort = 1'b1; grp.out_ready = 1'b0;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                chk_eq("abort_valid", grp.out_valid, 0);
                chk_eq("abort_busy", busy, 0);
                chk_eq("abort_done", done, 0);
                @(negedge clk);
                chk_eq("abort_done2", done, 0);
                chk_eq("abort_idle", busy, 0);
                return;
            end
            if (grp.out_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk_eq("group_count", idx, TOTAL);
        chk_eq("early_done", done_cnt, 0);
        chk_eq("done_pulse", done, 1);
        chk_eq("busy_after", busy, 0);
        chk_eq("valid_after", grp.out_valid, 0);
        if (chain) begin
            start = 1'b1; inv_mode = chain_inv;
        end
        @(negedge clk);
        start = 1'b0;
        chk_eq("done_single", done, 0);
    endtask

    task automatic rst_mid();
        start = 1'b1; inv_mode = 1'b0; grp.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("arst_valid", grp.out_valid, 0);
        chk_eq("arst_order", grp.order_o, 0);
        chk_eq("arst_stage", grp.stage_o, 0);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("arst_idle_busy", busy, 0);
        chk_eq("arst_idle_valid", grp.out_valid, 0);
        chk_eq("arst_idle_done", done, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; inv_mode = 1'b0; abort = 1'b0; grp.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_valid", grp.out_valid, 0);
        chk_eq("rst_order", grp.order_o, 0);
        chk_eq("rst_stage", grp.stage_o, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(1'b0, 100, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b1, 100, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b0, 100,  3, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b0,  60, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(1'b0, 100, -1, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b0,  70, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b1,  50, -1, -1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_job(1'b0,  80, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job(1'b1,  75,  5, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_mid();
        run_job(1'b1,  90, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
